// File: rtl/sa_result_drain.sv
// Write-back drain for systolic-array result lines: buffers N-byte lines in a FIFO and
// serializes them into addressed 32-bit little-endian words on a valid/ready stream.
module sa_result_drain #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wen_n,
  input  logic [AW-1:0]            waddr,
  input  logic [N-1:0][7:0]        data_in,
  input  logic                     frame_done,
  input  logic [31:0]              base_addr,
  input  logic                     clear,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [31:0]              m_addr,
  output logic [31:0]              m_data,
  output logic                     drain_done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned W  = N / 4;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  typedef struct packed {
    logic [31:0]      addr;
    logic [N*8-1:0]   data;
  } line_t;

  typedef enum logic {StIdle, StPend} state_e;

  line_t         mem [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] level_d;
  logic [IW-1:0] idx_q, idx_d;
  state_e        state_q, state_d;
  logic          valid_d, done_d, ovf_d;
  logic [31:0]   addr_d, data_d;
  logic          xfer, last, pop, full, push_req, push_ok;
  line_t         in_line, head;

  always_comb begin
    in_line.addr = base_addr + 32'(waddr) * 32'(N);
    in_line.data = data_in;

    xfer     = m_valid && m_ready;
    last     = (idx_q == IW'(W - 1));
    pop      = xfer && last;
    full     = (level == LW'(DEPTH));
    push_req = !wen_n && !clear;
    // A full FIFO still takes the line if the head retires on this same edge.
    push_ok  = push_req && (!full || pop);

    rd_d    = rd_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    level_d = level;
    state_d = state_q;
    ovf_d   = overflow;
    valid_d = m_valid;
    done_d  = 1'b0;
    addr_d  = m_addr;
    data_d  = m_data;
    head    = mem[rd_q];

    if (clear) begin
      rd_d    = '0;
      wr_d    = '0;
      idx_d   = '0;
      level_d = '0;
      state_d = StIdle;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      if (xfer) idx_d = last ? '0 : idx_q + 1'b1;
      if (pop) rd_d = rd_q + 1'b1;
      if (push_ok) wr_d = wr_q + 1'b1;
      level_d = level + LW'(push_ok) - LW'(pop);
      if (push_req && !push_ok) ovf_d = 1'b1;

      // Outputs are registered, so present the head of the post-edge FIFO; bypass the
      // incoming line when it lands straight at the head.
      head    = (push_ok && (rd_d == wr_q)) ? in_line : mem[rd_d];
      valid_d = (level_d != '0);
      if (valid_d) begin
        addr_d = head.addr + 32'(idx_d) * 32'd4;
        for (int k = 0; k < int'(W); k++) begin
          if (idx_d == IW'(k)) data_d = head.data[k*32 +: 32];
        end
      end

      if ((state_q == StPend || frame_done) && (level_d == '0)) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else if (frame_done) begin
        state_d = StPend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= in_line;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      wr_q       <= '0;
      idx_q      <= '0;
      level      <= '0;
      state_q    <= StIdle;
      overflow   <= 1'b0;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_data     <= '0;
      drain_done <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      level      <= level_d;
      state_q    <= state_d;
      overflow   <= ovf_d;
      m_valid    <= valid_d;
      m_addr     <= addr_d;
      m_data     <= data_d;
      drain_done <= done_d;
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: scoreboard of expected (addr, data) words, drained by a
// negedge monitor, plus directed checks of level, overflow, drain_done, clear and reset.
module tb_sa_result_drain;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 13;

  logic                   clk;
  logic                   rst_n;
  logic                   wen_n;
  logic [AW-1:0]          waddr;
  logic [N-1:0][7:0]      data_in;
  logic                   frame_done;
  logic [31:0]            base_addr;
  logic                   clear;
  logic                   m_valid;
  logic                   m_ready;
  logic [31:0]            m_addr;
  logic [31:0]            m_data;
  logic                   drain_done;
  logic                   overflow;
  logic [$clog2(DEPTH):0] level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int last_xfer_cyc = 0;
  int dd_cnt = 0;
  int dd_cyc = 0;
  logic [63:0] sb[$];

  sa_result_drain #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen_n      (wen_n),
    .waddr      (waddr),
    .data_in    (data_in),
    .frame_done (frame_done),
    .base_addr  (base_addr),
    .clear      (clear),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
    .m_data     (m_data),
    .drain_done (drain_done),
    .overflow   (overflow),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one push for a single edge; expected words are queued only if it should be kept.
  task automatic push_line(input logic [AW-1:0] wa, input logic [63:0] d, input bit accept);
    logic [31:0] la;
    wen_n   = 1'b0;
    waddr   = wa;
    data_in = d;
    if (accept) begin
      la = base_addr + 32'(wa) * 32'(N);
      for (int k = 0; k < int'(N / 4); k++) begin
        sb.push_back({la + 32'(4 * k), d[k*32 +: 32]});
      end
    end
    step();
    wen_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [63:0] exp;
    cyc++;
    if (rst_n && m_valid && m_ready) begin
      xfer_cnt++;
      last_xfer_cyc = cyc;
      exp = 'x;
      if (sb.size() > 0) exp = sb.pop_front();
      check("word", {m_addr, m_data}, exp);
    end
    if (drain_done) begin
      dd_cnt++;
      dd_cyc = cyc;
    end
  end

  initial begin
    int x0;
    int d0;
    rst_n      = 1'b0;
    wen_n      = 1'b1;
    waddr      = '0;
    data_in    = '0;
    frame_done = 1'b0;
    base_addr  = 32'h2000_0000;
    clear      = 1'b0;
    m_ready    = 1'b0;
    #1;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_addr", 64'(m_addr), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_done", 64'(drain_done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single line, ready held high.
    m_ready = 1'b1;
    x0 = xfer_cnt;
    push_line(13'd3, 64'h0807_0605_0403_0201, 1'b1);
    check("single_v0", 64'(m_valid), 64'd1);
    check("single_a0", 64'(m_addr), 64'h2000_0018);
    check("single_d0", 64'(m_data), 64'h0403_0201);
    step();
    check("single_a1", 64'(m_addr), 64'h2000_001C);
    check("single_d1", 64'(m_data), 64'h0807_0605);
    step();
    check("single_drop", 64'(m_valid), 64'd0);
    check("single_cnt", 64'(xfer_cnt - x0), 64'd2);

    // Backpressure: output held stable while not ready.
    m_ready = 1'b0;
    push_line(13'd5, 64'h1716_1514_1312_1110, 1'b1);
    push_line(13'd6, 64'h2726_2524_2322_2120, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(m_valid), 64'd1);
      check("bp_addr", 64'(m_addr), 64'h2000_0028);
      check("bp_data", 64'(m_data), 64'h1312_1110);
      check("bp_level", 64'(level), 64'd2);
      step();
    end
    x0 = xfer_cnt;
    m_ready = 1'b1;
    repeat (4) step();
    check("bp_cnt", 64'(xfer_cnt - x0), 64'd4);
    check("bp_drop", 64'(m_valid), 64'd0);
    check("bp_sb", 64'(sb.size()), 64'd0);

    // Overflow: two lines beyond depth are dropped.
    m_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      push_line(AW'(i + 16), {$urandom, $urandom}, i < int'(DEPTH));
    end
    check("ovf_level", 64'(level), 64'(DEPTH));
    check("ovf_flag", 64'(overflow), 64'd1);
    m_ready = 1'b1;
    repeat (2 * DEPTH) step();
    check("ovf_sb", 64'(sb.size()), 64'd0);
    check("ovf_drop", 64'(m_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    m_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_level", 64'(level), 64'd0);

    // Full FIFO with the head's last word retiring on the push edge.
    for (int i = 0; i < int'(DEPTH); i++) push_line(AW'(i + 40), {$urandom, $urandom}, 1'b1);
    check("fp_full", 64'(level), 64'(DEPTH));
    m_ready = 1'b1;
    step();
    push_line(13'd60, {$urandom, $urandom}, 1'b1);
    m_ready = 1'b0;
    check("fp_level", 64'(level), 64'(DEPTH));
    check("fp_ovf", 64'(overflow), 64'd0);
    m_ready = 1'b1;
    repeat (2 * DEPTH) step();
    check("fp_sb", 64'(sb.size()), 64'd0);
    check("fp_drop", 64'(m_valid), 64'd0);

    // frame_done with an empty FIFO completes on the next cycle.
    d0 = dd_cnt;
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    check("fd_empty_pulse", 64'(drain_done), 64'd1);
    step();
    check("fd_empty_low", 64'(drain_done), 64'd0);
    check("fd_empty_cnt", 64'(dd_cnt - d0), 64'd1);

    // Eight back-to-back lines, frame_done on the last, ready toggling.
    d0 = dd_cnt;
    x0 = xfer_cnt;
    for (int i = 0; i < 8; i++) begin
      m_ready    = i[0];
      frame_done = (i == 7);
      push_line(AW'(i + 100), {$urandom, $urandom}, 1'b1);
    end
    frame_done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      m_ready = ~m_ready;
      step();
    end
    check("frame_xfers", 64'(xfer_cnt - x0), 64'd16);
    check("frame_pulses", 64'(dd_cnt - d0), 64'd1);
    check("frame_timing", 64'(dd_cyc), 64'(last_xfer_cyc + 1));
    check("frame_sb", 64'(sb.size()), 64'd0);

    // Asynchronous reset while word 1 of a pending frame is presented.
    m_ready    = 1'b0;
    frame_done = 1'b1;
    push_line(13'd7, {$urandom, $urandom}, 1'b1);
    frame_done = 1'b0;
    m_ready = 1'b1;
    step();
    d0 = dd_cnt;
    m_ready = 1'b0;
    check("mid_word1", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", 64'(m_valid), 64'd0);
    check("mid_addr", 64'(m_addr), 64'd0);
    check("mid_data", 64'(m_data), 64'd0);
    check("mid_level", 64'(level), 64'd0);
    check("mid_done", 64'(drain_done), 64'd0);
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("mid_no_pulse", 64'(dd_cnt - d0), 64'd0);
    check("mid_idle", 64'(m_valid), 64'd0);

    // clear coinciding with a push drops both the held line and the new one.
    push_line(13'd8, {$urandom, $urandom}, 1'b1);
    check("cw_level1", 64'(level), 64'd1);
    clear   = 1'b1;
    wen_n   = 1'b0;
    waddr   = 13'd9;
    data_in = {$urandom, $urandom};
    step();
    clear = 1'b0;
    wen_n = 1'b1;
    sb.delete();
    check("cw_level0", 64'(level), 64'd0);
    check("cw_valid", 64'(m_valid), 64'd0);
    check("cw_ovf", 64'(overflow), 64'd0);
    step();
    check("cw_level_hold", 64'(level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
